// File: rtl/mips_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mips_seq_ctrl
// Brief   : Multi-cycle MIPS sequencer: fetch/decode/execute control with
//           memory-wait timeout, sticky error state and retired-instr count.
// Rev     : 1.0  initial release
// ============================================================================
module mips_seq_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_b,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        err,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE = 3'd0,
        C_ALUI  = 3'd1,
        C_LOAD  = 3'd2,
        C_STORE = 3'd3,
        C_BR    = 3'd4,
        C_JMP   = 3'd5,
        C_JAL   = 3'd6,
        C_ILL   = 3'd7
    } cls_t;

    localparam logic [8:0] c_TIMEOUT = 9'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_next;
    cls_t        r_cls;
    cls_t        w_dec_cls;
    logic [7:0]  r_wait;
    logic [15:0] r_count;
    logic        w_timeout;
    logic        w_boundary;

    // Timeout fires on the wait cycle that would bring the counter to the limit
    assign w_timeout = (({1'b0, r_wait} + 9'd1) == c_TIMEOUT);

    always_comb begin
        w_dec_cls = C_ILL;
        case (opcode)
            6'd0:                                     w_dec_cls = C_RTYPE;
            6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15: w_dec_cls = C_ALUI;
            6'd35:                                    w_dec_cls = C_LOAD;
            6'd43:                                    w_dec_cls = C_STORE;
            6'd4, 6'd5, 6'd32, 6'd33, 6'd34, 6'd36, 6'd37, 6'd38: w_dec_cls = C_BR;
            6'd2:                                     w_dec_cls = C_JMP;
            6'd3:                                     w_dec_cls = C_JAL;
            default:                                  w_dec_cls = C_ILL;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_boundary = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 1'b0;
        alu_src_b  = 1'b0;
        err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DECODE: begin
                case (w_dec_cls)
                    C_RTYPE, C_ALUI, C_LOAD, C_STORE: w_next = S_EXEC;
                    C_BR:                             w_next = S_BRANCH;
                    C_JMP, C_JAL:                     w_next = S_JUMP;
                    default:                          w_next = S_ERR;
                endcase
            end
            S_EXEC: begin
                alu_src_b = (r_cls != C_RTYPE);
                w_next    = (r_cls == C_LOAD || r_cls == C_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = (r_cls == C_STORE);
                if (mem_ready) begin
                    if (r_cls == C_STORE) w_boundary = 1'b1;
                    else                  w_next     = S_WB;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (r_cls == C_RTYPE) ? 2'b01 : 2'b00;
                mem_to_reg = (r_cls == C_LOAD);
                w_boundary = 1'b1;
            end
            S_BRANCH: begin
                pc_write   = branch_taken;
                pc_src     = 2'b01;
                w_boundary = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                if (r_cls == C_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b10;
                end
                w_boundary = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
        // run is only honoured between instructions
        if (w_boundary) w_next = run ? S_FETCH : S_IDLE;
    end

    assign instr_done  = w_boundary;
    assign state       = r_state;
    assign instr_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cls   <= C_RTYPE;
            r_wait  <= 8'd0;
            r_count <= 16'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_cls <= w_dec_cls;
            if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready)
                r_wait <= r_wait + 8'd1;
            else
                r_wait <= 8'd0;
            if (w_boundary) r_count <= r_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_seq_ctrl.sv
`default_nettype none
// Testbench for mips_seq_ctrl: per-instruction expected traces built from the
// opcode-class rules, compared against the DUT every cycle.
module tb_mips_seq_ctrl;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req, mem_we, i_or_d, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic        mem_to_reg, alu_src_b;
    logic [3:0]  state;
    logic        instr_done, err;
    logic [15:0] instr_count;

    mips_seq_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_b(alu_src_b), .state(state), .instr_done(instr_done),
        .err(err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       run;
        logic       mem_ready;
        logic       branch_taken;
        logic [5:0] opcode;
    } stim_t;

    typedef struct packed {
        logic [3:0]  state;
        logic        mem_req;
        logic        mem_we;
        logic        i_or_d;
        logic        ir_write;
        logic        pc_write;
        logic [1:0]  pc_src;
        logic        reg_write;
        logic [1:0]  reg_dst;
        logic        mem_to_reg;
        logic        alu_src_b;
        logic        instr_done;
        logic        err;
        logic [15:0] instr_count;
    } exp_t;

    stim_t       sq[$];
    exp_t        eq[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_count = 16'd0;
    int          m_where = 0;   // 0 idle, 1 about to fetch, 8 error
    int          n_mem, n_fetch, n_regw, n_we;

    // Opcode classes: 0 RTYPE 1 ALUI 2 LOAD 3 STORE 4 BR 5 JMP 6 JAL 7 ILLEGAL
    function automatic int cls_of(input logic [5:0] op);
        if (op == 6'd0) return 0;
        if (op inside {6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15}) return 1;
        if (op == 6'd35) return 2;
        if (op == 6'd43) return 3;
        if (op inside {6'd4, 6'd5, 6'd32, 6'd33, 6'd34, 6'd36, 6'd37, 6'd38}) return 4;
        if (op == 6'd2) return 5;
        if (op == 6'd3) return 6;
        return 7;
    endfunction

    function automatic exp_t blank(input int st);
        exp_t e;
        e = '0;
        e.state       = 4'(st);
        e.err         = (st == 8);
        e.instr_count = m_count;
        return e;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst_n        = 1'b1;
        s.run          = 1'($urandom_range(0, 1));
        s.mem_ready    = 1'($urandom_range(0, 1));
        s.branch_taken = 1'($urandom_range(0, 1));
        s.opcode       = 6'($urandom);
        return s;
    endfunction

    task automatic push(input stim_t s, input exp_t e);
        sq.push_back(s);
        eq.push_back(e);
    endtask

    task automatic boundary(input stim_t s, input exp_t e, input bit run_end);
        s.run        = run_end;
        e.instr_done = 1'b1;
        push(s, e);
        m_count = m_count + 16'd1;
        m_where = run_end ? 1 : 0;
    endtask

    task automatic start();
        stim_t s;
        if (m_where == 8) begin
            s = rnd();
            s.rst_n = 1'b0;
            m_count = 16'd0;
            push(s, blank(0));
            m_where = 0;
        end
        if (m_where == 0) begin
            int k = int'($urandom_range(0, 2));
            for (int i = 0; i < k; i++) begin
                s = rnd(); s.run = 1'b0; push(s, blank(0));
            end
            s = rnd(); s.run = 1'b1; push(s, blank(0));
            m_where = 1;
        end
    endtask

    task automatic err_cycles(input int n);
        if (m_where == 8)
            for (int i = 0; i < n; i++) push(rnd(), blank(8));
    endtask

    // Expected trace of one instruction: fw fetch waits, mw memory waits,
    // abort_mem >= 0 pulses reset at that memory-wait index.
    task automatic instr(input logic [5:0] op, input int fw, input int mw,
                         input bit bt, input bit run_end, input int abort_mem = -1);
        stim_t s;
        exp_t  e;
        int    c;
        start();
        c = cls_of(op);
        for (int i = 0; i < fw; i++) begin
            s = rnd(); s.mem_ready = 1'b0;
            e = blank(1); e.mem_req = 1'b1;
            push(s, e);
            if (i == T - 1) begin m_where = 8; return; end
        end
        s = rnd(); s.mem_ready = 1'b1;
        e = blank(1); e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(s, e);
        s = rnd(); s.opcode = op;
        push(s, blank(2));
        if (c == 7) begin m_where = 8; return; end
        if (c == 4) begin
            s = rnd(); s.branch_taken = bt;
            e = blank(6); e.pc_write = bt; e.pc_src = 2'b01;
            boundary(s, e, run_end);
            return;
        end
        if (c == 5 || c == 6) begin
            e = blank(7); e.pc_write = 1'b1; e.pc_src = 2'b10;
            if (c == 6) begin e.reg_write = 1'b1; e.reg_dst = 2'b10; end
            boundary(rnd(), e, run_end);
            return;
        end
        e = blank(3); e.alu_src_b = (c != 0);
        push(rnd(), e);
        if (c == 2 || c == 3) begin
            for (int i = 0; i < mw; i++) begin
                if (i == abort_mem) begin
                    s = rnd(); s.rst_n = 1'b0;
                    m_count = 16'd0;
                    push(s, blank(0));
                    m_where = 0;
                    return;
                end
                s = rnd(); s.mem_ready = 1'b0;
                e = blank(4); e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_we = (c == 3);
                push(s, e);
                if (i == T - 1) begin m_where = 8; return; end
            end
            s = rnd(); s.mem_ready = 1'b1;
            e = blank(4); e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_we = (c == 3);
            if (c == 3) begin boundary(s, e, run_end); return; end
            push(s, e);
        end
        e = blank(5); e.reg_write = 1'b1;
        e.reg_dst    = (c == 0) ? 2'b01 : 2'b00;
        e.mem_to_reg = (c == 2);
        boundary(rnd(), e, run_end);
    endtask

    task automatic compare(input exp_t e);
        exp_t a;
        a = {state, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
             reg_write, reg_dst, mem_to_reg, alu_src_b, instr_done, err, instr_count};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t actual=%h required=%h (state %0d vs %0d)",
                     $time, a, e, a.state, e.state);
        end
        if (state == 4'd4) n_mem++;
        if (state == 4'd1) n_fetch++;
        if (reg_write)     n_regw++;
        if (mem_we)        n_we++;
    endtask

    task automatic run_plan();
        stim_t s;
        exp_t  e;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            e = eq.pop_front();
            @(negedge clk);
            rst_n        = s.rst_n;
            run          = s.run;
            mem_ready    = s.mem_ready;
            branch_taken = s.branch_taken;
            opcode       = s.opcode;
            #1;
            compare(e);
        end
    endtask

    task automatic lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    logic [5:0] legal_ops [0:19] = '{6'd0, 6'd0, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13,
                                      6'd14, 6'd15, 6'd35, 6'd35, 6'd43, 6'd43,
                                      6'd4, 6'd5, 6'd32, 6'd38, 6'd2, 6'd3, 6'd3};

    initial begin
        #1;
        lit("reset_state", int'(state), 0);
        lit("reset_outputs", int'({mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                                   reg_write, reg_dst, mem_to_reg, alu_src_b,
                                   instr_done, err}), 0);
        lit("reset_count", int'(instr_count), 0);

        // R-type with immediate fetch, run low at the boundary
        instr(6'd0, 0, 0, 1'b0, 1'b0);
        run_plan();
        settle();
        lit("rtype_count", int'(instr_count), 1);
        lit("rtype_then_idle", int'(state), 0);

        // Load with three memory waits
        n_mem = 0;
        instr(6'd35, 1, 3, 1'b0, 1'b1);
        run_plan();
        lit("load_mem_cycles", n_mem, 4);

        // Store: write strobe every MEM cycle, never a register write
        n_regw = 0; n_we = 0;
        instr(6'd43, 0, 2, 1'b0, 1'b1);
        run_plan();
        lit("store_regwrite", n_regw, 0);
        lit("store_we_cycles", n_we, 3);

        // Branch taken / not taken, then JAL
        instr(6'd4, 0, 0, 1'b1, 1'b1);
        instr(6'd4, 0, 0, 1'b0, 1'b1);
        instr(6'd3, 0, 0, 1'b0, 1'b1);
        run_plan();

        // Ready on the 15th wait cycle completes; 15 misses time out
        instr(6'd8, 14, 0, 1'b0, 1'b1);
        run_plan();
        n_fetch = 0;
        instr(6'd0, 15, 0, 1'b0, 1'b1);
        err_cycles(3);
        run_plan();
        lit("timeout_fetch_cycles", n_fetch, 15);
        lit("timeout_err_sticky", int'(err), 1);

        // Illegal opcode
        instr(6'd63, 0, 0, 1'b0, 1'b1);
        err_cycles(2);
        run_plan();
        lit("illegal_err", int'(err), 1);

        // Reset pulsed in the middle of a memory wait
        instr(6'd0, 0, 0, 1'b0, 1'b1);
        instr(6'd35, 0, 5, 1'b0, 1'b1, 2);
        run_plan();
        lit("midmem_reset_state", int'(state), 0);
        lit("midmem_reset_memreq", int'(mem_req), 0);
        lit("midmem_reset_count", int'(instr_count), 0);

        // Randomized instruction mix
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            int fw, mw;
            op = legal_ops[$urandom_range(0, 19)];
            if ($urandom_range(0, 19) == 0) op = 6'($urandom_range(0, 63));
            fw = ($urandom_range(0, 29) == 0) ? T : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 29) == 0) ? T + 1 : int'($urandom_range(0, 4));
            instr(op, fw, mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            err_cycles(int'($urandom_range(1, 3)));
            run_plan();
        end

        // Count up to 0xFFFF, then one more retirement wraps to zero
        while (m_count != 16'hFFFF) begin
            instr(6'd2, 0, 0, 1'b0, m_count != 16'hFFFE);
            run_plan();
        end
        settle();
        lit("count_at_ffff", int'(instr_count), 65535);
        instr(6'd8, 0, 0, 1'b0, 1'b0);
        run_plan();
        settle();
        lit("count_wrap", int'(instr_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
